// File: rtl/spi_adc_receiver.sv
// SPI slave deserialiser for the external ADC link: synchronises the SPI pins,
// shifts words in MSB-first, tags them with a rotating channel index and
// discards partial words after an idle timeout.
// Optional macro SPI_ADC_RX_ERRCOUNT_EN adds a saturating error_count output.
module spi_adc_receiver #(
    parameter int WORD_BITS = 16,
    parameter int CHANNELS  = 1,
    parameter int TIMEOUT   = 64,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 spi_clock_in,
    input  logic                 spi_data_in,
    output logic [WORD_BITS-1:0] data_out,
    output logic [CH_W-1:0]      channel_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
`ifdef SPI_ADC_RX_ERRCOUNT_EN
    ,
    output logic [7:0]           error_count
`endif
);

    localparam int BC_W   = $clog2(WORD_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(WORD_BITS - 1);
    localparam logic [CH_W-1:0]   LAST_CHAN = CH_W'(CHANNELS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_HIT  = IDLE_W'(TIMEOUT - 1);

    logic                 clk_s1, clk_s2, clk_s3;
    logic                 dat_s1, dat_s2;
    logic                 rise;
    logic [WORD_BITS-1:0] shreg;
    logic [WORD_BITS-1:0] next_word;
    logic [BC_W-1:0]      bit_count;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [CH_W-1:0]      chan;

    // Clock and data share the same two-flop depth so the data bit seen at
    // dat_s2 is the one that was stable when the SPI clock rose.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_s3 <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= spi_clock_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= spi_data_in;
            dat_s2 <= dat_s1;
        end
    end

    assign rise      = clk_s2 & ~clk_s3;
    assign next_word = {shreg[WORD_BITS-2:0], dat_s2};
    assign busy      = (bit_count != '0);

    // A rise always wins over the idle timeout because it clears the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg       <= '0;
            bit_count   <= '0;
            idle_cnt    <= '0;
            chan        <= '0;
            data_out    <= '0;
            channel_out <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (rise) begin
                idle_cnt <= '0;
                shreg    <= next_word;
                if (bit_count == LAST_BIT) begin
                    data_out    <= next_word;
                    channel_out <= chan;
                    data_valid  <= 1'b1;
                    bit_count   <= '0;
                    chan        <= (chan == LAST_CHAN) ? '0 : chan + CH_W'(1);
                end else begin
                    bit_count <= bit_count + BC_W'(1);
                end
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_HIT) begin
                    chan <= '0;
                    if (bit_count != '0) begin
                        frame_error <= 1'b1;
                        bit_count   <= '0;
                    end
                end
            end
        end
    end

`ifdef SPI_ADC_RX_ERRCOUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            error_count <= '0;
        end else if (frame_error && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_adc_receiver.sv
// Directed self-checking bench for spi_adc_receiver: three instances cover the
// default build, a 3-channel frame and a 12-bit word with a mid-word reset.
`timescale 1ns/1ps
module tb_spi_adc_receiver;

    logic clock = 1'b0;
    logic reset, reset_c;
    logic spi_clk_a, spi_dat_a, spi_clk_b, spi_dat_b, spi_clk_c, spi_dat_c;

    logic [15:0] data_a;
    logic [0:0]  chan_a;
    logic        dv_a, fe_a, busy_a;
    logic [15:0] data_b;
    logic [1:0]  chan_b;
    logic        dv_b, fe_b, busy_b;
    logic [11:0] data_c;
    logic [0:0]  chan_c;
    logic        dv_c, fe_c, busy_c;
`ifdef SPI_ADC_RX_ERRCOUNT_EN
    logic [7:0]  errcnt_a, errcnt_b, errcnt_c;
`endif

    int checks = 0;
    int errors = 0;
    int fe_cnt_a = 0, fe_cnt_b = 0, fe_cnt_c = 0;
    int overlap = 0;
    logic [31:0] q_data_a[$], q_data_b[$], q_data_c[$];
    logic [31:0] q_chan_a[$], q_chan_b[$], q_chan_c[$];

    always #41 clock = ~clock;

    spi_adc_receiver #(.WORD_BITS(16), .CHANNELS(1), .TIMEOUT(64)) dut_a (
        .clock(clock), .reset(reset), .spi_clock_in(spi_clk_a), .spi_data_in(spi_dat_a),
        .data_out(data_a), .channel_out(chan_a), .data_valid(dv_a), .frame_error(fe_a),
        .busy(busy_a)
`ifdef SPI_ADC_RX_ERRCOUNT_EN
        , .error_count(errcnt_a)
`endif
    );

    spi_adc_receiver #(.WORD_BITS(16), .CHANNELS(3), .TIMEOUT(64)) dut_b (
        .clock(clock), .reset(reset), .spi_clock_in(spi_clk_b), .spi_data_in(spi_dat_b),
        .data_out(data_b), .channel_out(chan_b), .data_valid(dv_b), .frame_error(fe_b),
        .busy(busy_b)
`ifdef SPI_ADC_RX_ERRCOUNT_EN
        , .error_count(errcnt_b)
`endif
    );

    spi_adc_receiver #(.WORD_BITS(12), .CHANNELS(1), .TIMEOUT(64)) dut_c (
        .clock(clock), .reset(reset_c), .spi_clock_in(spi_clk_c), .spi_data_in(spi_dat_c),
        .data_out(data_c), .channel_out(chan_c), .data_valid(dv_c), .frame_error(fe_c),
        .busy(busy_c)
`ifdef SPI_ADC_RX_ERRCOUNT_EN
        , .error_count(errcnt_c)
`endif
    );

    // Pulse recorder, sampled on the inactive edge.
    always @(negedge clock) begin
        if (dv_a) begin q_data_a.push_back(32'(data_a)); q_chan_a.push_back(32'(chan_a)); end
        if (dv_b) begin q_data_b.push_back(32'(data_b)); q_chan_b.push_back(32'(chan_b)); end
        if (dv_c) begin q_data_c.push_back(32'(data_c)); q_chan_c.push_back(32'(chan_c)); end
        if (fe_a) fe_cnt_a++;
        if (fe_b) fe_cnt_b++;
        if (fe_c) fe_cnt_c++;
        if ((dv_a && fe_a) || (dv_b && fe_b) || (dv_c && fe_c)) overlap++;
    end

    task automatic set_spi(input int inst, input logic c, input logic d);
        case (inst)
            0:       begin spi_clk_a = c; spi_dat_a = d; end
            1:       begin spi_clk_b = c; spi_dat_b = d; end
            default: begin spi_clk_c = c; spi_dat_c = d; end
        endcase
    endtask

    task automatic send_range(input int inst, input logic [31:0] word, input int msb,
                              input int lsb, input int half_ns);
        for (int i = msb; i >= lsb; i--) begin
            set_spi(inst, 1'b0, word[i]);
            #(half_ns);
            set_spi(inst, 1'b1, word[i]);
            #(half_ns);
        end
        set_spi(inst, 1'b0, 1'b0);
    endtask

    task automatic clear_records();
        q_data_a.delete(); q_chan_a.delete();
        q_data_b.delete(); q_chan_b.delete();
        q_data_c.delete(); q_chan_c.delete();
        fe_cnt_a = 0; fe_cnt_b = 0; fe_cnt_c = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_c = 1'b1;
        set_spi(0, 1'b0, 1'b0); set_spi(1, 1'b0, 1'b0); set_spi(2, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; reset_c = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (data_a !== 16'h0) begin errors++; $display("[TB] FAIL reset_data_a: got %0h expected 0", data_a); end
        checks++; if (chan_a !== 1'b0)  begin errors++; $display("[TB] FAIL reset_chan_a: got %0h expected 0", chan_a); end
        checks++; if (dv_a !== 1'b0 || fe_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses_a: got dv=%b fe=%b expected 0 0", dv_a, fe_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (chan_b !== 2'd0 || busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_b: got chan=%0d busy=%b expected 0 0", chan_b, busy_b); end
        checks++; if (data_c !== 12'h0 || busy_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_c: got data=%0h busy=%b expected 0 0", data_c, busy_c); end
`ifdef SPI_ADC_RX_ERRCOUNT_EN
        checks++; if (errcnt_a !== 8'd0) begin errors++; $display("[TB] FAIL reset_errcnt: got %0d expected 0", errcnt_a); end
`endif
    endtask

    task automatic test_single_word();
        clear_records();
        send_range(0, 32'h96AA, 15, 0, 375);
        repeat (10) @(negedge clock);
        checks++; if (q_data_a.size() != 1) begin errors++; $display("[TB] FAIL single_valid_count: got %0d expected 1", q_data_a.size()); end
        checks++; if (data_a !== 16'h96AA) begin errors++; $display("[TB] FAIL single_data: got %0h expected 96aa", data_a); end
        checks++; if (chan_a !== 1'b0) begin errors++; $display("[TB] FAIL single_chan: got %0d expected 0", chan_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got %b expected 0", busy_a); end
        checks++; if (fe_cnt_a != 0) begin errors++; $display("[TB] FAIL single_frame_error: got %0d expected 0", fe_cnt_a); end
    endtask

    // Edge k=1 is the first clock edge that samples the final SPI clock high;
    // the rise is consumed at k=3 so the 64-clock timeout lands at k=67.
    task automatic test_short_packet();
        clear_records();
        send_range(0, 32'h96AA, 15, 2, 375);
        @(negedge clock);
        set_spi(0, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        set_spi(0, 1'b1, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            @(posedge clock);
            #1;
            if (k == 5) set_spi(0, 1'b0, 1'b0);
            if (k == 10) begin
                checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL short_busy_mid: got %b expected 1", busy_a); end
            end
            if (k == 66) begin
                checks++; if (fe_a !== 1'b0) begin errors++; $display("[TB] FAIL short_fe_early: got %b expected 0", fe_a); end
            end
            if (k == 67) begin
                checks++; if (fe_a !== 1'b1) begin errors++; $display("[TB] FAIL short_fe_timing: got %b expected 1", fe_a); end
            end
            if (k == 68) begin
                checks++; if (fe_a !== 1'b0) begin errors++; $display("[TB] FAIL short_fe_width: got %b expected 0", fe_a); end
            end
        end
        checks++; if (fe_cnt_a != 1) begin errors++; $display("[TB] FAIL short_fe_count: got %0d expected 1", fe_cnt_a); end
        checks++; if (q_data_a.size() != 0) begin errors++; $display("[TB] FAIL short_no_valid: got %0d expected 0", q_data_a.size()); end
        checks++; if (data_a !== 16'h96AA) begin errors++; $display("[TB] FAIL short_data_kept: got %0h expected 96aa", data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL short_busy_after: got %b expected 0", busy_a); end
`ifdef SPI_ADC_RX_ERRCOUNT_EN
        checks++; if (errcnt_a !== 8'd1) begin errors++; $display("[TB] FAIL short_errcnt: got %0d expected 1", errcnt_a); end
`endif
    endtask

    task automatic test_realign();
        clear_records();
        send_range(0, 32'h5533, 15, 0, 375);
        repeat (10) @(negedge clock);
        checks++; if (q_data_a.size() != 1) begin errors++; $display("[TB] FAIL realign_count: got %0d expected 1", q_data_a.size()); end
        else begin
            checks++; if (q_data_a[0] !== 32'h5533) begin errors++; $display("[TB] FAIL realign_data: got %0h expected 5533", q_data_a[0]); end
        end
        checks++; if (fe_cnt_a != 0) begin errors++; $display("[TB] FAIL realign_fe: got %0d expected 0", fe_cnt_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[4];
        logic [31:0] chans[4];
        words = '{32'h1655, 32'hAACC, 32'h96AA, 32'h0001};
        chans = '{32'd0, 32'd1, 32'd2, 32'd0};
        clear_records();
        for (int w = 0; w < 4; w++) send_range(1, words[w], 15, 0, 400);
        repeat (10) @(negedge clock);
        checks++; if (q_data_b.size() != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", q_data_b.size()); end
        else begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (q_chan_b[w] !== chans[w]) begin errors++; $display("[TB] FAIL b2b_chan%0d: got %0d expected %0d", w, q_chan_b[w], chans[w]); end
                checks++; if (q_data_b[w] !== words[w]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %0h expected %0h", w, q_data_b[w], words[w]); end
            end
        end
        checks++; if (fe_cnt_b != 0) begin errors++; $display("[TB] FAIL b2b_fe: got %0d expected 0", fe_cnt_b); end
    endtask

    task automatic test_boundary_timeout();
        logic [31:0] words[3];
        logic [31:0] chans[3];
        words = '{32'h1234, 32'hBEEF, 32'h0F0F};
        chans = '{32'd0, 32'd1, 32'd0};
        repeat (100) @(negedge clock);
        clear_records();
        send_range(1, words[0], 15, 0, 400);
        send_range(1, words[1], 15, 0, 400);
        repeat (100) @(negedge clock);
        send_range(1, words[2], 15, 0, 400);
        repeat (10) @(negedge clock);
        checks++; if (q_chan_b.size() != 3) begin errors++; $display("[TB] FAIL bound_count: got %0d expected 3", q_chan_b.size()); end
        else begin
            for (int w = 0; w < 3; w++) begin
                checks++; if (q_chan_b[w] !== chans[w] || q_data_b[w] !== words[w]) begin
                    errors++; $display("[TB] FAIL bound_word%0d: got chan=%0d data=%0h expected chan=%0d data=%0h", w, q_chan_b[w], q_data_b[w], chans[w], words[w]);
                end
            end
        end
        checks++; if (fe_cnt_b != 0) begin errors++; $display("[TB] FAIL bound_fe: got %0d expected 0", fe_cnt_b); end
    endtask

    // Final rise is first sampled at k=1; data_valid is registered at k=3 and
    // is therefore seen by downstream logic on the third edge after k=1.
    task automatic test_reset_mid_word();
        clear_records();
        send_range(2, 32'hABC, 11, 6, 375);
        @(negedge clock);
        checks++; if (busy_c !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy_c); end
        reset_c = 1'b1;
        repeat (2) @(negedge clock);
        reset_c = 1'b0;
        @(negedge clock);
        checks++; if (busy_c !== 1'b0 || data_c !== 12'h0) begin errors++; $display("[TB] FAIL midreset_clear: got busy=%b data=%0h expected 0 0", busy_c, data_c); end
        send_range(2, 32'hABC, 11, 1, 375);
        @(negedge clock);
        set_spi(2, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        set_spi(2, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            if (k == 5) set_spi(2, 1'b0, 1'b0);
            if (k == 2) begin
                checks++; if (dv_c !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got %b expected 0", dv_c); end
            end
            if (k == 3) begin
                checks++; if (dv_c !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid: got %b expected 1", dv_c); end
            end
            if (k == 4) begin
                checks++; if (dv_c !== 1'b0) begin errors++; $display("[TB] FAIL latency_width: got %b expected 0", dv_c); end
            end
        end
        repeat (80) @(negedge clock);
        checks++; if (q_data_c.size() != 1) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 1", q_data_c.size()); end
        checks++; if (data_c !== 12'hABC) begin errors++; $display("[TB] FAIL midreset_data: got %0h expected abc", data_c); end
        checks++; if (fe_cnt_c != 0) begin errors++; $display("[TB] FAIL midreset_fe: got %0d expected 0", fe_cnt_c); end
    endtask

    task automatic test_no_overlap();
        checks++; if (overlap != 0) begin errors++; $display("[TB] FAIL valid_error_overlap: got %0d expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_short_packet();
        test_realign();
        test_back_to_back();
        test_boundary_timeout();
        test_reset_mid_word();
        test_no_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
